// File: rtl/audio_pkg.sv
// Shared types and constants for the ADSR envelope / VCA path.
package audio_pkg;

    localparam int ENVBITS = 16;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    function automatic int unsigned MIDSCALE(input int unsigned bitdepth);
        return 32'd1 << (bitdepth - 1);
    endfunction

endpackage

// File: rtl/adsr_vca_if.sv
// Control, sample and status signals between the oscillator, the VCA and the dac.
interface adsr_vca_if #(
    parameter int BITDEPTH = 12
);
    logic                sample_clock;
    logic                gate;
    logic [7:0]          attack_rate;
    logic [7:0]          decay_rate;
    logic [7:0]          sustain_level;
    logic [7:0]          release_rate;
    logic [BITDEPTH-1:0] pcm_in;
    logic [BITDEPTH-1:0] pcm_out;
    logic                out_valid;
    logic [7:0]          env_level;
    logic                active;

    modport master (
        output sample_clock, gate, attack_rate, decay_rate,
        output sustain_level, release_rate, pcm_in,
        input  pcm_out, out_valid, env_level, active
    );

    modport slave (
        input  sample_clock, gate, attack_rate, decay_rate,
        input  sustain_level, release_rate, pcm_in,
        output pcm_out, out_valid, env_level, active
    );
endinterface

// File: rtl/envelope_fsm.sv
// Sample-tick detector, ADSR state machine and envelope accumulator.
module envelope_fsm
    import audio_pkg::*;
#(
    parameter int ENVBITS = audio_pkg::ENVBITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_clock,
    input  logic               gate,
    input  logic [7:0]         attack_rate,
    input  logic [7:0]         decay_rate,
    input  logic [7:0]         sustain_level,
    input  logic [7:0]         release_rate,
    output logic [ENVBITS-1:0] env,
    output logic               tick,
    output env_state_t         state
);

    localparam logic [ENVBITS-1:0] ENV_MAX = '1;

    logic                      sc_d;
    env_state_t                state_q;
    env_state_t                state_d;
    logic [ENVBITS-1:0]        env_q;
    logic [ENVBITS-1:0]        env_d;
    logic [ENVBITS-1:0]        target;
    logic [ENVBITS:0]          sum;
    logic signed [ENVBITS:0]   dec;

    assign tick   = sample_clock & ~sc_d;
    assign target = {sustain_level, {(ENVBITS-8){1'b0}}};
    assign sum    = {1'b0, env_q} + {{(ENVBITS-7){1'b0}}, attack_rate};
    assign dec    = $signed({1'b0, env_q})
                  - $signed({{(ENVBITS-7){1'b0}}, decay_rate});

    assign env   = env_q;
    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_d    <= 1'b0;
            state_q <= ENV_IDLE;
            env_q   <= '0;
        end else begin
            sc_d    <= sample_clock;
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    // Gate release wins over every in-note transition on the same tick.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (tick) begin
            unique case (state_q)
                ENV_IDLE: begin
                    if (gate) state_d = ENV_ATTACK;
                end
                ENV_ATTACK: begin
                    if (!gate) begin
                        state_d = ENV_RELEASE;
                    end else if (attack_rate == 8'd0 || sum >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = ENV_DECAY;
                    end else begin
                        env_d = sum[ENVBITS-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (!gate) begin
                        state_d = ENV_RELEASE;
                    end else if (decay_rate == 8'd0 || dec <= $signed({1'b0, target})) begin
                        env_d   = target;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        env_d = dec[ENVBITS-1:0];
                    end
                end
                ENV_SUSTAIN: begin
                    if (!gate) state_d = ENV_RELEASE;
                    else       env_d   = target;
                end
                ENV_RELEASE: begin
                    if (gate) begin
                        state_d = ENV_ATTACK;
                    end else if (release_rate == 8'd0
                                 || env_q <= {{(ENVBITS-8){1'b0}}, release_rate}) begin
                        env_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        env_d = env_q - {{(ENVBITS-8){1'b0}}, release_rate};
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ENV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/adsr_vca.sv
// ADSR-controlled amplifier: scales offset-binary PCM around midscale
// by the envelope gain through a two-stage pipeline.
module adsr_vca
    import audio_pkg::*;
#(
    parameter int BITDEPTH = 12,
    parameter int ENVBITS  = audio_pkg::ENVBITS
) (
    input  logic       clk,
    input  logic       rst_n,
    adsr_vca_if.slave  bus
);

    localparam int PW = BITDEPTH + 10;
    localparam logic [BITDEPTH-1:0] MID = BITDEPTH'(MIDSCALE(BITDEPTH));

    logic [ENVBITS-1:0]     env;
    logic                   tick;
    env_state_t             state;
    logic [7:0]             gain;

    logic [BITDEPTH-1:0]    s_reg;
    logic signed [PW-1:0]   p_reg;
    logic [BITDEPTH-1:0]    pcm_q;
    logic                   valid_q;
    logic                   v1;
    logic                   v2;

    logic signed [BITDEPTH:0] c;
    logic signed [PW-1:0]     cw;
    logic signed [PW-1:0]     gw;
    logic signed [PW-1:0]     prod;
    logic                     unused_bits;

    envelope_fsm #(
        .ENVBITS(ENVBITS)
    ) u_env (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_clock (bus.sample_clock),
        .gate         (bus.gate),
        .attack_rate  (bus.attack_rate),
        .decay_rate   (bus.decay_rate),
        .sustain_level(bus.sustain_level),
        .release_rate (bus.release_rate),
        .env          (env),
        .tick         (tick),
        .state        (state)
    );

    assign gain = env[ENVBITS-1 -: 8];

    // Gain is at most 255/256, so the product never needs the top two bits.
    assign c    = $signed({1'b0, s_reg}) - $signed({1'b0, MID});
    assign cw   = {{9{c[BITDEPTH]}}, c};
    assign gw   = {{(BITDEPTH+2){1'b0}}, gain};
    assign prod = cw * gw;

    assign unused_bits = ^{env[ENVBITS-9:0], p_reg[PW-1:PW-2], p_reg[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= MID;
            p_reg   <= '0;
            pcm_q   <= MID;
            valid_q <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
        end else begin
            v1      <= tick;
            v2      <= v1;
            valid_q <= v2;
            if (tick) s_reg <= bus.pcm_in;
            if (v1)   p_reg <= prod;
            if (v2)   pcm_q <= p_reg[BITDEPTH+7:8] + MID;
        end
    end

    assign bus.pcm_out   = pcm_q;
    assign bus.out_valid = valid_q;
    assign bus.env_level = gain;
    assign bus.active    = (state != ENV_IDLE);

endmodule

// File: tb/tb_adsr_vca.sv
// Randomized and directed checks of adsr_vca against a per-tick envelope model.
module tb_adsr_vca;

    localparam int BD  = 12;
    localparam int MID = 2048;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    adsr_vca_if #(.BITDEPTH(BD)) bus ();

    adsr_vca #(
        .BITDEPTH(BD),
        .ENVBITS (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int nchk = 0;
    int nerr = 0;
    bit cmp_on = 1'b0;
    int last_out;

    // model state
    int m_st  = S_IDLE;
    int m_env = 0;
    int m_sc  = 0;
    int m_d1  = 0;
    int m_d1v = MID;
    int m_d2  = 0;
    int m_d2v = MID;
    int m_val = 0;
    int m_out = MID;
    int m_tk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int scale(input int pin, input int g);
        int c;
        int p;
        c = pin - MID;
        p = c * g;
        return ((p >>> 8) + MID) & 4095;
    endfunction

    function automatic void model_step();
        int g, ar, dr, t, rr;
        g  = int'(bus.gate);
        ar = int'(bus.attack_rate);
        dr = int'(bus.decay_rate);
        t  = int'(bus.sustain_level) * 256;
        rr = int'(bus.release_rate);
        case (m_st)
            S_IDLE: if (g != 0) m_st = S_ATT;
            S_ATT: begin
                if (g == 0) m_st = S_REL;
                else if (ar == 0 || m_env + ar >= 65535) begin
                    m_env = 65535;
                    m_st  = S_DEC;
                end else m_env = m_env + ar;
            end
            S_DEC: begin
                if (g == 0) m_st = S_REL;
                else if (dr == 0 || m_env - dr <= t) begin
                    m_env = t;
                    m_st  = S_SUS;
                end else m_env = m_env - dr;
            end
            S_SUS: begin
                if (g == 0) m_st = S_REL;
                else m_env = t;
            end
            default: begin
                if (g != 0) m_st = S_ATT;
                else if (rr == 0 || m_env <= rr) begin
                    m_env = 0;
                    m_st  = S_IDLE;
                end else m_env = m_env - rr;
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = S_IDLE; m_env = 0; m_sc = 0;
            m_d1 = 0; m_d2 = 0; m_val = 0; m_out = MID;
        end else begin
            m_tk  = (bus.sample_clock && m_sc == 0) ? 1 : 0;
            m_sc  = int'(bus.sample_clock);
            m_val = m_d2;
            if (m_d2 != 0) m_out = m_d2v;
            m_d2  = m_d1;
            m_d2v = m_d1v;
            m_d1  = m_tk;
            if (m_tk != 0) begin
                model_step();
                m_d1v = scale(int'(bus.pcm_in), m_env >> 8);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("env_level", 32'(bus.env_level), 32'(m_env >> 8));
            check("active",    32'(bus.active),    32'(m_st != S_IDLE));
            check("out_valid", 32'(bus.out_valid), 32'(m_val));
            check("pcm_out",   32'(bus.pcm_out),   32'(m_out));
        end
    end

    // One sample_clock period: high for h clocks, n clocks total.
    task automatic tick(input int h, input int n);
        @(negedge clk);
        bus.sample_clock = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == h) bus.sample_clock = 1'b0;
            if (i == 3) begin
                check("latency", 32'(bus.out_valid), 32'd1);
                last_out = int'(bus.pcm_out);
            end
        end
        bus.sample_clock = 1'b0;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick(4, 7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.sample_clock  = 1'b0;
        bus.gate          = 1'b0;
        bus.attack_rate   = 8'd0;
        bus.decay_rate    = 8'd0;
        bus.sustain_level = 8'd0;
        bus.release_rate  = 8'd0;
        bus.pcm_in        = 12'h800;
        #1 rst_n = 1'b0;
        cmp_on = 1'b1;
        #3;
        check("rst_pcm_out",   32'(bus.pcm_out),   32'd2048);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_env_level", 32'(bus.env_level), 32'd0);
        check("rst_active",    32'(bus.active),    32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // attack and decay
        bus.attack_rate = 8'd255; bus.decay_rate = 8'd16;
        bus.sustain_level = 8'h80; bus.gate = 1'b1;
        tick(4, 7);
        check("attack_enter_active", 32'(bus.active), 32'd1);
        check("attack_enter_level",  32'(bus.env_level), 32'd0);
        ticks(257);
        check("attack_peak", 32'(bus.env_level), 32'd255);
        ticks(2048);
        check("decay_sustain", 32'(bus.env_level), 32'h80);
        bus.sustain_level = 8'h60;
        tick(4, 7);
        check("sustain_track", 32'(bus.env_level), 32'h60);

        // instant release
        bus.gate = 1'b0; bus.release_rate = 8'd0;
        tick(4, 7);
        check("release_enter", 32'(bus.env_level), 32'h60);
        tick(4, 7);
        check("release_idle_level",  32'(bus.env_level), 32'd0);
        check("release_idle_active", 32'(bus.active), 32'd0);

        // scaling at gain 255 and 0
        bus.attack_rate = 8'd0; bus.decay_rate = 8'd1;
        bus.sustain_level = 8'd0; bus.gate = 1'b1;
        ticks(2);
        bus.pcm_in = 12'hFFF; tick(4, 7);
        check("scale_fff", 32'(last_out), 32'd4087);
        bus.pcm_in = 12'h000; tick(4, 7);
        check("scale_000", 32'(last_out), 32'd8);
        bus.pcm_in = 12'h800; tick(4, 7);
        check("scale_800", 32'(last_out), 32'd2048);
        bus.gate = 1'b0; ticks(2);
        bus.pcm_in = 12'hFFF; tick(4, 7);
        check("scale_gain0", 32'(last_out), 32'd2048);

        // retrigger from release at 0x4000
        bus.decay_rate = 8'd0; bus.sustain_level = 8'h40; bus.gate = 1'b1;
        ticks(3);
        bus.gate = 1'b0; bus.release_rate = 8'h10;
        tick(4, 7);
        bus.gate = 1'b1; bus.attack_rate = 8'h10;
        tick(4, 7);
        check("retrig_level",  32'(bus.env_level), 32'h40);
        check("retrig_active", 32'(bus.active), 32'd1);
        tick(4, 7);
        bus.attack_rate = 8'hF0;
        tick(4, 7);
        check("retrig_resume", 32'(bus.env_level), 32'h41);

        // gate pulse between ticks
        bus.gate = 1'b0; bus.release_rate = 8'd0;
        ticks(2);
        @(negedge clk) bus.gate = 1'b1;
        repeat (2) @(negedge clk);
        bus.gate = 1'b0;
        tick(4, 7);
        check("pulse_ignored", 32'(bus.active), 32'd0);

        // reset mid-note, then sample_clock already high at release
        bus.attack_rate = 8'd0; bus.decay_rate = 8'd1; bus.gate = 1'b1;
        bus.pcm_in = 12'hFFF;
        ticks(2);
        check("pre_reset_out", 32'(last_out), 32'd4087);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_rst_pcm",    32'(bus.pcm_out), 32'd2048);
        check("async_rst_level",  32'(bus.env_level), 32'd0);
        check("async_rst_active", 32'(bus.active), 32'd0);
        bus.sample_clock = 1'b1;
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sc_high_at_release", 32'(bus.active), 32'd1);
        bus.sample_clock = 1'b0;
        repeat (3) @(negedge clk);

        // randomized notes
        for (int it = 0; it < 500; it++) begin
            int h;
            if ($urandom_range(0, 5) == 0) bus.gate = ~bus.gate;
            if ($urandom_range(0, 7) == 0)
                bus.attack_rate = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                bus.decay_rate = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                bus.sustain_level = 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                bus.release_rate = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            bus.pcm_in = 12'($urandom);
            if (it == 250) begin
                @(negedge clk); #2 rst_n = 1'b0;
                @(negedge clk); #2 rst_n = 1'b1;
            end
            h = $urandom_range(1, 4);
            tick(h, h + $urandom_range(2, 4));
        end

        repeat (4) @(negedge clk);
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
